// File: rtl/frecdiv_pkg.sv
// ---------------------------------------------------------------------------
// frecdiv_pkg
//
// Shared constants and helpers for the multi-channel frequency divider.
//
//   CLK_HZ      system clock frequency the half-period presets assume
//   HALF_1KHZ   half-period preset for a 1 kHz output (default DEF_HALF)
//   HALF_100HZ  half-period preset for a 100 Hz output
//   HALF_1HZ    half-period preset for a 1 Hz output
//   clog2()     ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package frecdiv_pkg;

    localparam int CLK_HZ     = 100_000_000;

    // Half-period presets in system clock cycles: CLK_HZ / (2 * f_out).
    localparam int HALF_1KHZ  = 50_000;
    localparam int HALF_100HZ = 500_000;
    localparam int HALF_1HZ   = 50_000_000;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frecdiv_chan.sv
// ---------------------------------------------------------------------------
// frecdiv_chan
//
// One divider channel.
//
// The channel has two copies of the half-period. The active copy, half_q,
// drives the counter compare. The shadow copy, half_sh_q, is loaded by the
// write bus. The shadow moves into the active register only at a half-period
// boundary or while the channel is held idle. This keeps cnt_q < half_q at all
// times, so a write never makes the output glitch.
//
// Optional build macro: FRECDIV_SYNC_EN adds the sync_in port. A high sync_in
// restarts a running channel in the same way that disabling it would.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-low reset
//   wr_en    in   write strobe for this channel's shadow register
//   wr_data  in   new half-period; values 0 and 1 are stored as 1
//   en       in   run enable
//   sync_in  in   phase-align restart (only when FRECDIV_SYNC_EN is defined)
//   clk_k    out  divided clock, 50% duty, period 2*half
//   tick     out  one-cycle pulse in the cycle clk_k rises
//   pend     out  shadow written but not yet applied
// ---------------------------------------------------------------------------
module frecdiv_chan
    import frecdiv_pkg::*;
#(
    parameter int CW       = 26,
    parameter int DEF_HALF = HALF_1KHZ
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_data,
    input  logic          en,
`ifdef FRECDIV_SYNC_EN
    input  logic          sync_in,
`endif
    output logic          clk_k,
    output logic          tick,
    output logic          pend
);

    localparam logic [CW-1:0] HALF_RST = CW'(DEF_HALF);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q,     cnt_d;
    logic [CW-1:0] half_q,    half_d;
    logic [CW-1:0] half_sh_q, half_sh_d;
    logic          pend_q,    pend_d;
    logic          clk_k_q,   clk_k_d;
    logic          tick_q,    tick_d;

    logic          restart;
    logic          apply;
    logic [CW-1:0] wr_half;

    // A half-period of 0 would never wrap. Clamp it to the fastest legal rate, clk/2.
    assign wr_half = (wr_data <= ONE) ? ONE : wr_data;

    always_comb begin
        restart = !en;
`ifdef FRECDIV_SYNC_EN
        // The alignment restart applies only to channels that are running.
        // An idle channel is already held at phase zero.
        if (en && sync_in) begin
            restart = 1'b1;
        end
`endif
    end

    always_comb begin
        // NOTE: every _d starts from its _q value, so no branch can leave it unassigned and infer a latch.
        cnt_d     = cnt_q;
        half_d    = half_q;
        half_sh_d = half_sh_q;
        pend_d    = pend_q;
        clk_k_d   = clk_k_q;
        tick_d    = 1'b0;
        apply     = 1'b0;

        if (restart) begin
            // Idle, or realigning: hold at phase zero and output low.
            // A pending shadow is applied here, while cnt is zero.
            cnt_d   = '0;
            clk_k_d = 1'b0;
            apply   = pend_q;
        end else if (cnt_q == half_q - ONE) begin
            // Half-period boundary. Toggle the output, and tick only on a
            // rising edge. The shadow becomes active for the next half.
            cnt_d   = '0;
            clk_k_d = ~clk_k_q;
            tick_d  = ~clk_k_q;
            apply   = pend_q;
        end else begin
            cnt_d   = cnt_q + ONE;
        end

        if (apply) begin
            half_d = half_sh_q;
            pend_d = 1'b0;
        end

        // The write is evaluated last. A write in the same cycle as an apply
        // therefore leaves its own value pending, while the apply above has
        // already used the pre-edge shadow.
        if (wr_en) begin
            half_sh_d = wr_half;
            pend_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            half_q    <= HALF_RST;
            half_sh_q <= HALF_RST;
            pend_q    <= 1'b0;
            clk_k_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            half_sh_q <= half_sh_d;
            pend_q    <= pend_d;
            clk_k_q   <= clk_k_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_k = clk_k_q;
    assign tick  = tick_q;
    assign pend  = pend_q;

endmodule

// File: rtl/frec_divider_multi.sv
// ---------------------------------------------------------------------------
// frec_divider_multi
//
// NCH independent clock dividers running from the 100 MHz system clock.
// Each channel has its own half-period. Software loads a new half-period
// through the port-bus write interface (wr_en / wr_ch / wr_data). The new
// value takes effect at the channel's next half-period boundary, or at once
// if the channel is disabled.
//
// Optional build macro: FRECDIV_SYNC_EN adds the sync_in input. Pulsing
// sync_in restarts every enabled channel together, which phase-aligns their
// outputs.
//
// Ports
//   clk      in   system clock, 100 MHz
//   reset    in   synchronous active-low reset
//   wr_en    in   write strobe
//   wr_ch    in   target channel; values >= NCH are ignored
//   wr_data  in   new half-period in clk cycles
//   ch_en    in   per-channel run enable
//   sync_in  in   phase-align pulse (FRECDIV_SYNC_EN only)
//   clk_k    out  per-channel divided clock
//   tick     out  per-channel rising-edge pulse
//   pend     out  per-channel "shadow written, not yet applied"
// ---------------------------------------------------------------------------
module frec_divider_multi
    import frecdiv_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CW       = 26,
    parameter int DEF_HALF = HALF_1KHZ,
    parameter int CHW      = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_data,
    input  logic [NCH-1:0] ch_en,
`ifdef FRECDIV_SYNC_EN
    input  logic           sync_in,
`endif
    output logic [NCH-1:0] clk_k,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_sel;

        // Decode the write target. When NCH is not a power of two, the codes
        // from NCH upward match no channel, so those writes are dropped.
        assign wr_sel = wr_en && (wr_ch == CHW'(i));

        frecdiv_chan #(
            .CW       (CW),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_sel),
            .wr_data (wr_data),
            .en      (ch_en[i]),
`ifdef FRECDIV_SYNC_EN
            .sync_in (sync_in),
`endif
            .clk_k   (clk_k[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_frec_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_frec_divider_multi
//
// Self-checking bench for frec_divider_multi. It uses three channels, so that
// wr_ch == NCH is a reachable code, and a short reset half-period, so that
// each scenario completes in a few hundred cycles. The reference model tracks,
// for each channel, the number of cycles left in the current half-period. It
// updates that count from the input values present at each clock edge.
// ---------------------------------------------------------------------------
module tb_frec_divider_multi;

    localparam int NCH  = 3;
    localparam int CW   = 16;
    localparam int HALF = 50;
    localparam int CHW  = 2;
    localparam int LIMIT = 1000;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [CW-1:0]  wr_data = '0;
    logic [NCH-1:0] ch_en = '0;
    logic           sync_in = 1'b0;
    logic [NCH-1:0] clk_k;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state for each channel.
    int m_left [NCH];
    int m_half [NCH];
    int m_sh   [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];
    bit m_pend [NCH];

    frec_divider_multi #(
        .NCH      (NCH),
        .CW       (CW),
        .DEF_HALF (HALF),
        .CHW      (CHW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .ch_en   (ch_en),
`ifdef FRECDIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .clk_k   (clk_k),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit restart;
            restart = !ch_en[c];
`ifdef FRECDIV_SYNC_EN
            if (sync_in) restart = 1'b1;
`endif
            if (!reset) begin
                m_half[c] = HALF; m_sh[c] = HALF; m_left[c] = HALF;
                m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
                continue;
            end
            if (restart) begin
                m_lvl[c] = 0; m_tick[c] = 0;
                if (m_pend[c]) begin m_half[c] = m_sh[c]; m_pend[c] = 0; end
                m_left[c] = m_half[c];
            end else begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_lvl[c]  = !m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    if (m_pend[c]) begin m_half[c] = m_sh[c]; m_pend[c] = 0; end
                    m_left[c] = m_half[c];
                end else begin
                    m_tick[c] = 0;
                end
            end
            if (wr_en && wr_ch == c) begin
                m_sh[c]   = (wr_data < 2) ? 1 : int'(wr_data);
                m_pend[c] = 1;
            end
        end
    endtask

    function automatic logic [3*NCH-1:0] model_vec();
        logic [NCH-1:0] a, b, p;
        for (int c = 0; c < NCH; c++) begin
            a[c] = m_lvl[c]; b[c] = m_tick[c]; p[c] = m_pend[c];
        end
        return {a, b, p};
    endfunction

    // One clock edge: update the model at the edge, then wait 1 ns so that
    // outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_level(input int ch, input logic lvl, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (clk_k[ch] !== lvl && n < LIMIT);
    endtask

    task automatic write(input int ch, input int data);
        wr_en = 1'b1; wr_ch = CHW'(ch); wr_data = CW'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ch_en = '0;
        repeat (10) step();
        n_total++;
        if ({clk_k, tick, pend} !== '0) $display("FAIL reset_outputs: got %b required 0", {clk_k, tick, pend});
        else n_pass++;
        n_total++;
        if ({clk_k, tick, pend} !== model_vec()) $display("FAIL reset_model: got %b required %b", {clk_k, tick, pend}, model_vec());
        else n_pass++;
    endtask

    task automatic test_default_period();
        int n, a, b, ticks;
        bit ch1_hi;
        reset = 1'b1; ch_en = 3'b001;
        wait_level(0, 1'b1, n);
        n_total++;
        if (n !== HALF) $display("FAIL first_rise: got %0d cycles required %0d", n, HALF);
        else n_pass++;
        wait_level(0, 1'b0, a);
        wait_level(0, 1'b1, b);
        n_total++;
        if (a !== HALF || b !== HALF) $display("FAIL default_period: got high %0d low %0d required %0d each", a, b, HALF);
        else n_pass++;
        ticks = 0; ch1_hi = 0;
        for (int k = 0; k < 2 * HALF; k++) begin
            step();
            ticks += int'(tick[0]);
            if (clk_k[1] !== 1'b0) ch1_hi = 1;
        end
        n_total++;
        if (ticks !== 1 || ch1_hi) $display("FAIL tick_per_period: got ticks %0d ch1_high %0d required 1 and 0", ticks, ch1_hi);
        else n_pass++;
        n_total++;
        if ({clk_k, tick, pend} !== model_vec()) $display("FAIL default_model: got %b required %b", {clk_k, tick, pend}, model_vec());
        else n_pass++;
    endtask

    task automatic test_write_mid_half();
        int n, a, b;
        ch_en = 3'b011;
        repeat (20) step();
        write(1, 5);
        n_total++;
        if (pend[1] !== 1'b1) $display("FAIL pend_set: got %b required 1", pend[1]);
        else n_pass++;
        n = 0;
        while (pend[1] === 1'b1 && n < LIMIT) begin step(); n++; end
        n_total++;
        if (n !== HALF - 21 || clk_k[1] !== 1'b1 || tick[1] !== 1'b1)
            $display("FAIL pend_clear_at_wrap: got %0d cycles clk %b tick %b required %0d 1 1", n, clk_k[1], tick[1], HALF - 21);
        else n_pass++;
        wait_level(1, 1'b0, a);
        wait_level(1, 1'b1, b);
        n_total++;
        if (a !== 5 || b !== 5) $display("FAIL new_half_5: got high %0d low %0d required 5 5", a, b);
        else n_pass++;
        n_total++;
        if ({clk_k, tick, pend} !== model_vec()) $display("FAIL mid_half_model: got %b required %b", {clk_k, tick, pend}, model_vec());
        else n_pass++;
    endtask

    task automatic test_write_zero_disabled();
        ch_en = 3'b010;
        step();
        write(0, 0);
        n_total++;
        if (pend[0] !== 1'b1) $display("FAIL zero_pend_set: got %b required 1", pend[0]);
        else n_pass++;
        step();
        n_total++;
        if (pend[0] !== 1'b0 || clk_k[0] !== 1'b0) $display("FAIL zero_applied_idle: got pend %b clk %b required 0 0", pend[0], clk_k[0]);
        else n_pass++;
        ch_en = 3'b011;
        for (int k = 1; k <= 8; k++) begin
            logic exp;
            step();
            exp = (k % 2 == 1);
            n_total++;
            if (clk_k[0] !== exp || tick[0] !== exp)
                $display("FAIL clk_div2_cycle%0d: got clk %b tick %b required %b %b", k, clk_k[0], tick[0], exp, exp);
            else n_pass++;
        end
    endtask

    task automatic test_disable_midhigh();
        int n;
        write(0, 8);
        wait_level(0, 1'b0, n);
        wait_level(0, 1'b1, n);
        repeat (3) step();
        n_total++;
        if (clk_k[0] !== 1'b1 || pend[0] !== 1'b0) $display("FAIL still_high: got clk %b pend %b required 1 0", clk_k[0], pend[0]);
        else n_pass++;
        ch_en[0] = 1'b0;
        step();
        n_total++;
        if (clk_k[0] !== 1'b0 || tick[0] !== 1'b0) $display("FAIL disable_low: got clk %b tick %b required 0 0", clk_k[0], tick[0]);
        else n_pass++;
        ch_en[0] = 1'b1;
        wait_level(0, 1'b1, n);
        n_total++;
        if (n !== 8) $display("FAIL reenable_rise: got %0d cycles required 8", n);
        else n_pass++;
    endtask

    task automatic test_write_on_wrap();
        int n;
        logic [NCH-1:0] pend_before;
        ch_en = 3'b111;
        repeat (3) step();
        write(2, 6);
        n = 0;
        while (m_left[2] != 1 && n < LIMIT) begin step(); n++; end
        write(2, 9);
        n_total++;
        if (pend[2] !== 1'b1 || clk_k[2] !== 1'b1) $display("FAIL wrap_write: got pend %b clk %b required 1 1", pend[2], clk_k[2]);
        else n_pass++;
        repeat (5) step();
        n_total++;
        if (pend[2] !== 1'b1 || clk_k[2] !== 1'b1) $display("FAIL pend_between: got pend %b clk %b required 1 1", pend[2], clk_k[2]);
        else n_pass++;
        step();
        n_total++;
        if (pend[2] !== 1'b0 || clk_k[2] !== 1'b0) $display("FAIL old_applied_6: got pend %b clk %b required 0 0", pend[2], clk_k[2]);
        else n_pass++;
        wait_level(2, 1'b1, n);
        n_total++;
        if (n !== 9) $display("FAIL new_applied_9: got %0d cycles required 9", n);
        else n_pass++;
        // A write to a channel code past the last channel must change nothing.
        pend_before = pend;
        write(NCH, 2);
        n_total++;
        if (pend !== pend_before) $display("FAIL bad_ch_pend: got %b required %b", pend, pend_before);
        else n_pass++;
        wait_level(2, 1'b0, n);
        n_total++;
        if (n !== 8) $display("FAIL bad_ch_half: got %0d cycles required 8", n);
        else n_pass++;
        n_total++;
        if ({clk_k, tick, pend} !== model_vec()) $display("FAIL wrap_model: got %b required %b", {clk_k, tick, pend}, model_vec());
        else n_pass++;
    endtask

    task automatic test_midrun_reset();
        int n;
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_total++;
        if ({clk_k, tick, pend} !== '0) $display("FAIL reset_mid: got %b required 0", {clk_k, tick, pend});
        else n_pass++;
        wait_level(0, 1'b1, n);
        n_total++;
        if (n !== HALF || clk_k !== 3'b111 || tick !== 3'b111)
            $display("FAIL reset_default_aligned: got %0d cycles clk %b tick %b required %0d 111 111", n, clk_k, tick, HALF);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            wr_en   = ($urandom % 6 == 0);
            wr_ch   = CHW'($urandom % 4);
            wr_data = CW'($urandom % 13);
            if ($urandom % 30 == 0) ch_en = NCH'($urandom);
            reset   = ($urandom % 400 != 0);
`ifdef FRECDIV_SYNC_EN
            sync_in = ($urandom % 50 == 0);
`endif
            step();
            n_total++;
            if ({clk_k, tick, pend} !== model_vec())
                $display("FAIL random_cycle%0d: got %b required %b", k, {clk_k, tick, pend}, model_vec());
            else n_pass++;
        end
        wr_en = 1'b0; reset = 1'b1; sync_in = 1'b0;
    endtask

`ifdef FRECDIV_SYNC_EN
    task automatic test_sync();
        int n;
        ch_en = '0;
        step();
        write(0, 4);
        write(1, 4);
        step();
        ch_en = 3'b001;
        repeat (3) step();
        ch_en = 3'b011;
        repeat (2) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        n_total++;
        if (clk_k[1:0] !== 2'b00) $display("FAIL sync_low: got %b required 00", clk_k[1:0]);
        else n_pass++;
        wait_level(0, 1'b1, n);
        n_total++;
        if (n !== 4 || clk_k[1] !== 1'b1) $display("FAIL sync_aligned: got %0d cycles ch1 %b required 4 1", n, clk_k[1]);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_default_period();
        test_write_mid_half();
        test_write_zero_disabled();
        test_disable_midhigh();
        test_write_on_wrap();
        test_midrun_reset();
`ifdef FRECDIV_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frec_divider_multi.md
Name: frec_divider_multi

Overview:
Parametrised successor of the fixed 100 MHz -> 1 kHz divider. It generates NCH independent divided clocks from the 100 MHz system clock. Each channel has a half-period divisor that software loads at runtime from the PicoBlaze port bus, a per-channel enable, and a one-cycle rising-edge tick for synchronous logic. It feeds the RTC controller timing (1 kHz scan, 1 Hz blink, and similar).

Parameters:
NCH, 2, number of divider channels (1..8)
CW, 26, width of the counter and divisor registers; must hold DEF_HALF-1 and the largest divisor written
DEF_HALF, 50000, half-period value loaded at reset (100 MHz -> 1 kHz)
CHW, 1, width of wr_ch; CHW = max(1, clog2(NCH))

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low reset (0 sampled at a clk edge resets the block)
wr_en  in  1  write strobe for the divisor shadow register
wr_ch  in  CHW  channel select for the write
wr_data  in  CW  new half-period value, in clk cycles
ch_en  in  NCH  per-channel run enable
clk_k  out  NCH  divided clock, 50% duty, period 2*half cycles
tick  out  NCH  one-cycle pulse, high in the same cycle clk_k[i] rises
pend  out  NCH  shadow written but not yet applied

Behaviour:
- Per-channel registers: cnt[CW], half[CW] (active), half_sh[CW] (shadow), pend, clk_k, tick. All outputs are registered.
- Reset (reset==0 at a clk edge), highest priority:
  - cnt=0, half=half_sh=DEF_HALF, pend=0, clk_k=0, tick=0 on every channel.
  - A low pulse between clk edges has no effect.
- Running (ch_en[i]=1):
  - If cnt==half-1: cnt<=0 and clk_k toggles.
    - tick<=1 only when clk_k goes 0->1; otherwise tick<=0.
    - If pend=1: half<=half_sh and pend<=0, so the new value applies from the next half-period.
  - Otherwise: cnt<=cnt+1 and tick<=0.
  - The first clk_k rise after reset or enable occurs half cycles after the first enabled edge. After that the period is 2*half.
- Disabled (ch_en[i]=0):
  - cnt<=0, clk_k<=0, tick<=0.
  - If pend=1, the shadow applies on that edge (half<=half_sh, pend<=0).
- Write (wr_en=1, wr_ch<NCH):
  - half_sh[wr_ch]<=wr_data and pend[wr_ch]<=1.
  - wr_data of 0 or 1 is stored as 1 (clk/2, tick every 2 cycles).
  - wr_ch>=NCH: the write is ignored and nothing changes.
- Write in the same cycle as a wrap or disable on that channel:
  - The apply uses the pre-edge half_sh.
  - The new write lands in half_sh and pend ends at 1; the write wins.
- Because half only changes at cnt==half-1 or while cnt==0, cnt<half always holds. No out-of-range compare exists.
- Channels share no state apart from the write bus.

Optional Feature:
- Macro FRECDIV_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - When sync_in=1, every channel with ch_en=1 takes cnt<=0, clk_k<=0, tick<=0, and applies its pending shadow. This phase-aligns all outputs.
  - Priority: below reset, above wrap and count.
  - A write in the same cycle behaves as in the wrap case.
- Undefined: no sync_in port and no alignment logic.

Decomposition:
- Package frecdiv_pkg:
  - DEF_HALF presets HALF_1KHZ=50000, HALF_1HZ=50000000, HALF_100HZ=500000.
  - clog2 constant function.
  - CLK_HZ=100000000.
- Sub-module frecdiv_chan: one channel (cnt, half, shadow, pend, clk_k, tick), instantiated NCH times in a generate loop.
- The top level decodes wr_ch into per-channel write strobes.

Test Plan:
1. reset=0 for 100 ns, then reset=1, ch_en=2'b01 -> clk_k[0] first rises 50000 cycles after release, period 100000 cycles (1 ms), exactly one tick per period; clk_k[1]=0.
2. ch1 running at default, write wr_ch=1, wr_data=5 mid-half -> pend[1]=1 until the current half ends; then high 5 and low 5 cycles (period 10); pend[1] returns to 0.
3. Write wr_data=0 to ch0 while ch0 is disabled -> pend applies next edge; after enable, clk_k[0] toggles every cycle and tick[0] pulses every 2nd cycle.
4. Drop ch_en[0] mid-high-phase -> clk_k[0]=0 and cnt=0 next edge; re-enable -> first rise after half cycles.
5. Write on the exact wrap cycle with the old shadow pending -> old value applies at this wrap, new value at the next wrap, pend stays 1 between them. Write with wr_ch=NCH -> no register change.
6. Pull reset low for one cycle mid-run -> all channels return to DEF_HALF with outputs 0. With FRECDIV_SYNC_EN: pulse sync_in with two channels at different phases -> both restart aligned and their rising edges coincide.
